// File: rtl/mmio_timer_responder_if.sv
// rtl/mmio_timer_responder_if.sv - data-memory bus bundle shared by the core, main memory and the timer
interface mmio_timer_responder_if;
    logic        write_mem;
    logic [2:0]  funct3;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic [31:0] read_address;
    logic [31:0] read_data;
    logic        read_hit;

    modport master (
        output write_mem, funct3, write_address, write_data, read_address,
        input  read_data, read_hit
    );

    modport slave (
        input  write_mem, funct3, write_address, write_data, read_address,
        output read_data, read_hit
    );
endinterface

// File: rtl/mmio_timer_responder.sv
// rtl/mmio_timer_responder.sv - memory-mapped prescaled timer with compare match and level irq
module mmio_timer_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          PRESCALE_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    mmio_timer_responder_if.slave   bus,
    output logic                    irq
);
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    logic [2:0]            ctrl;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcount;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  match;

    logic ctrl_en, ctrl_auto, ctrl_irq_en;
    assign ctrl_en     = ctrl[0];
    assign ctrl_auto   = ctrl[1];
    assign ctrl_irq_en = ctrl[2];

    // Offsets are taken relative to BASE_ADDR so the decode is independent of its value.
    logic [31:0] wr_off, rd_off;
    logic        wr_in_range, rd_in_range;
    logic [2:0]  wr_idx, rd_idx;
    assign wr_off      = bus.write_address - BASE_ADDR;
    assign rd_off      = bus.read_address - BASE_ADDR;
    assign wr_in_range = (wr_off[31:5] == 27'd0) && (wr_off[4:0] < 5'h14);
    assign rd_in_range = (rd_off[31:5] == 27'd0) && (rd_off[4:0] < 5'h14);
    assign wr_idx      = wr_off[4:2];
    assign rd_idx      = rd_off[4:2];

    logic [3:0]  wr_lanes;
    logic [31:0] wr_word;
    always_comb begin
        wr_lanes = 4'b0000;
        wr_word  = 32'd0;
        case (bus.funct3)
            3'b000: begin
                wr_lanes = 4'b0001 << wr_off[1:0];
                wr_word  = {4{bus.write_data[7:0]}};
            end
            3'b001: begin
                if (!wr_off[0]) wr_lanes = wr_off[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{bus.write_data[15:0]}};
            end
            3'b010: begin
                if (wr_off[1:0] == 2'b00) wr_lanes = 4'b1111;
                wr_word = bus.write_data;
            end
            default: begin
                wr_lanes = 4'b0000;
                wr_word  = 32'd0;
            end
        endcase
    end

    logic wr_en;
    assign wr_en = bus.write_mem && wr_in_range && (wr_lanes != 4'b0000);

    logic [31:0] wr_cur;
    always_comb begin
        case (wr_idx)
            REG_CTRL:     wr_cur = {29'd0, ctrl};
            REG_PRESCALE: wr_cur = 32'(prescale);
            REG_COUNT:    wr_cur = count;
            REG_COMPARE:  wr_cur = compare;
            REG_STATUS:   wr_cur = {31'd0, match};
            default:      wr_cur = 32'd0;
        endcase
    end

    logic [31:0] byte_mask, wr_merged;
    always_comb begin
        byte_mask = 32'd0;
        for (int i = 0; i < 4; i++) byte_mask[8*i +: 8] = {8{wr_lanes[i]}};
        wr_merged = (wr_cur & ~byte_mask) | (wr_word & byte_mask);
    end

    // W1C looks only at freshly written data, never at the merged-back old bit.
    logic cnt_write, status_w1c;
    assign cnt_write  = wr_en && (wr_idx == REG_COUNT);
    assign status_w1c = wr_en && (wr_idx == REG_STATUS) && wr_lanes[0] && wr_word[0];

    logic tick, cmp_hit, match_set;
    assign tick      = ctrl_en && (pcount == prescale);
    assign cmp_hit   = (count == compare);
    assign match_set = tick && cmp_hit && !cnt_write;

    logic [31:0] rd_cur, rd_shifted, rd_sized;
    always_comb begin
        case (rd_idx)
            REG_CTRL:     rd_cur = {29'd0, ctrl};
            REG_PRESCALE: rd_cur = 32'(prescale);
            REG_COUNT:    rd_cur = count;
            REG_COMPARE:  rd_cur = compare;
            REG_STATUS:   rd_cur = {31'd0, match};
            default:      rd_cur = 32'd0;
        endcase
        rd_shifted = rd_cur >> {rd_off[1:0], 3'b000};
        case (bus.funct3)
            3'b000:  rd_sized = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  rd_sized = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  rd_sized = {24'd0, rd_shifted[7:0]};
            3'b101:  rd_sized = {16'd0, rd_shifted[15:0]};
            default: rd_sized = rd_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl          <= 3'd0;
            prescale      <= '0;
            pcount        <= '0;
            count         <= 32'd0;
            compare       <= 32'd0;
            match         <= 1'b0;
            bus.read_data <= 32'd0;
            bus.read_hit  <= 1'b0;
        end else begin
            if (ctrl_en) pcount <= tick ? '0 : pcount + PRESCALE_W'(1);

            if (cnt_write)
                count <= wr_merged;
            else if (tick)
                count <= (cmp_hit && ctrl_auto) ? 32'd0 : count + 32'd1;

            if (match_set)
                match <= 1'b1;
            else if (status_w1c)
                match <= 1'b0;

            // Later assignment to pcount lets a disabling CTRL write override the timer step.
            if (wr_en) begin
                case (wr_idx)
                    REG_CTRL: begin
                        ctrl <= wr_merged[2:0];
                        if (!wr_merged[0]) pcount <= '0;
                    end
                    REG_PRESCALE: prescale <= wr_merged[PRESCALE_W-1:0];
                    REG_COMPARE:  compare  <= wr_merged;
                    default: ;
                endcase
            end

            bus.read_hit  <= rd_in_range;
            bus.read_data <= rd_in_range ? rd_sized : 32'd0;
        end
    end

    assign irq = match & ctrl_irq_en;
endmodule

// File: doc/mmio_timer_responder.md
Name: mmio_timer_responder

Overview:
- Memory-mapped timer peripheral that responds to the core's data-memory bus: the same write_mem/funct3/write_address/write_data/read_address/read_data signalling the core drives into main memory.
- Sits beside main memory; top muxes read_data using read_hit.
- Provides a prescaled 32-bit counter, compare match, write-1-to-clear status flag and a level interrupt output.

Parameters:
- BASE_ADDR, 32'hFFFF_FF00, byte address of register 0; the block decodes BASE_ADDR..BASE_ADDR+0x13.
- PRESCALE_W, 16, width of the prescale register and internal prescale counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- write_mem  input  1  store strobe, one cycle per store
- funct3  input  3  access size: stores 000 SB / 001 SH / 010 SW; loads 000 LB / 001 LH / 010 LW / 100 LBU / 101 LHU
- write_address  input  32  store byte address
- write_data  input  32  store data, right-aligned as in the register file
- read_address  input  32  load byte address, sampled every cycle
- read_data  output  32  registered load result, size/sign-adjusted
- read_hit  output  1  registered; 1 when read_data belongs to this block
- irq  output  1  STATUS.match & CTRL.irq_en

Behaviour:
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL: bit0 en, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 PRESCALE: bits [PRESCALE_W-1:0].
  - 0x08 COUNT: 32 bits.
  - 0x0C COMPARE: 32 bits.
  - 0x10 STATUS: bit0 match, write-1-to-clear.
- Reset: every register, the prescale counter, read_data, read_hit and irq = 0.
- Writes:
  - Take effect on the edge where write_mem=1 and write_address is in range.
  - Byte lanes are selected by write_address[1:0]. SB writes lane addr[1:0]. SH writes lanes {addr[1],0},{addr[1],1}. SW writes all lanes.
  - Misaligned SH (addr[0]=1) or SW (addr[1:0]!=0) is ignored.
  - Out-of-range addresses and funct3 values other than 000/001/010 are ignored.
- Reads:
  - Latency is one cycle. read_address and funct3 are sampled at edge N; read_data and read_hit are valid after edge N.
  - The word is shifted right by 8*addr[1:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - An out-of-range address gives read_data=0 and read_hit=0.
  - Reads have no side effects.
- Timer, while CTRL.en=1:
  - The prescale counter increments each cycle.
  - When prescale counter == PRESCALE, a tick occurs and the prescale counter returns to 0. PRESCALE=0 therefore ticks every cycle.
  - On a tick with COUNT==COMPARE: STATUS.match<=1. COUNT<=0 if auto_reload, else COUNT+1.
  - On a tick otherwise: COUNT<=COUNT+1, wrapping 0xFFFF_FFFF -> 0.
- While CTRL.en=0: the counters hold. A write that clears en also zeroes the prescale counter.
- Simultaneous events:
  - A software write to COUNT in the same cycle as a tick: the write wins, and no match is evaluated that cycle.
  - A W1C of STATUS in the same cycle as a match set: the set wins, and match stays 1.
  - Writing a 0 to STATUS.match has no effect.
- irq is combinational from registered state only, so it is glitch-free at the edge.
- Reset mid-operation: all state returns to reset values on the next edge. A read issued in the reset cycle returns 0 with read_hit=0.

Test Plan:
- Reset, then read 0x00..0x10 -> read_data=0 one cycle after each address; read_hit=1; irq=0.
- SW COMPARE=0x5, PRESCALE=1, CTRL=0x7 -> COUNT increments every 2 cycles. The tick at COUNT==5 sets STATUS.match=1 and irq=1, and COUNT returns to 0.
- SB 0xAB to COUNT+2 when COUNT=0 (en=0) -> COUNT=0x00AB_0000. LB at COUNT+2 -> 0xFFFF_FFAB. LBU -> 0x0000_00AB. Misaligned SW to COUNT+1 -> COUNT unchanged.
- With match=1, SW STATUS=0x1 -> match=0 and irq=0 next cycle. Repeat a W1C landing on the same edge as a new match -> match stays 1.
- auto_reload=0, COUNT=0xFFFF_FFFF, COMPARE=0x10, PRESCALE=0, en=1 -> next cycle COUNT=0, no match; 16 cycles later COUNT=0x10 and match is set on the following tick.
- Assert reset for one cycle mid-count with irq=1 -> after the edge all registers are 0, irq=0, read_hit=0; reads to 0x0000_0100 (out of range) -> read_hit=0, read_data=0.
